// File: rtl/dino_score_bcd.sv
// Dino game score counter: packed-BCD score driven by a frame-tick divider,
// high-score register, new-high flag and 100-point milestone pulse.

module dino_bcd_digit (
  input  logic [3:0] d,
  input  logic       cin,
  output logic [3:0] q
);
  always_comb begin
    q = d;
    if (cin) q = (d == 4'd9) ? 4'd0 : d + 4'd1;
  end
endmodule

module dino_score_bcd #(
  parameter int DIGITS          = 4,
  parameter int TICKS_PER_POINT = 6,
  parameter int SATURATE        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  game_start,
  input  logic                  game_over,
  input  logic                  game_tick,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hiscore,
  output logic                  running,
  output logic                  new_hi,
  output logic                  milestone
);
  localparam int DIV_W = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICKS_PER_POINT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [4*DIGITS-1:0]  score_d, hiscore_d, score_inc;
  logic                 new_hi_d, milestone_d;
  logic                 start_q, over_q, tick_q;
  logic                 start_ev, over_ev, tick_ev;
  logic [DIGITS-1:0]    nine;
  logic [DIGITS:0]      carry;

  // Edge registers come out of reset high so a level held through reset is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b1;
      over_q  <= 1'b1;
      tick_q  <= 1'b1;
    end else begin
      start_q <= game_start;
      over_q  <= game_over;
      tick_q  <= game_tick;
    end
  end

  assign start_ev = game_start & ~start_q;
  assign over_ev  = game_over  & ~over_q;
  assign tick_ev  = game_tick  & ~tick_q;

  // Carry into digit g is "every lower digit is 9"; built from score alone to keep it loop-free.
  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign nine[g]      = (score[4*g +: 4] == 4'd9);
    assign carry[g+1]   = &nine[g:0];
    dino_bcd_digit u_dig (
      .d   (score[4*g +: 4]),
      .cin (carry[g]),
      .q   (score_inc[4*g +: 4])
    );
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score;
    hiscore_d   = hiscore;
    div_d       = div_q;
    new_hi_d    = new_hi;
    milestone_d = 1'b0;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_ev) begin
          state_d  = S_RUN;
          score_d  = '0;
          div_d    = '0;
          new_hi_d = 1'b0;
        end
      end
      S_RUN: begin
        if (over_ev) begin
          state_d = S_OVER;
          // Packed BCD orders the same as unsigned binary.
          if (score > hiscore) begin
            hiscore_d = score;
            new_hi_d  = 1'b1;
          end
        end else if (tick_ev) begin
          if (div_q == DIV_MAX) begin
            div_d = '0;
            if (!((SATURATE != 0) && carry[DIGITS])) begin
              score_d     = score_inc;
              milestone_d = carry[2];
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      score     <= '0;
      hiscore   <= '0;
      div_q     <= '0;
      new_hi    <= 1'b0;
      milestone <= 1'b0;
      running   <= 1'b0;
    end else begin
      state_q   <= state_d;
      score     <= score_d;
      hiscore   <= hiscore_d;
      div_q     <= div_d;
      new_hi    <= new_hi_d;
      milestone <= milestone_d;
      running   <= (state_d == S_RUN);
    end
  end
endmodule

// File: tb/tb_dino_score_bcd.sv
// Directed bench for dino_score_bcd: default build plus two 3-digit builds
// (saturating and wrapping) for the max-score behaviour.

module tb_dino_score_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, over_a = 1'b0, tick_a = 1'b0;
  logic start_s = 1'b0, over_s = 1'b0, tick_s = 1'b0;
  logic [15:0] score_a, hiscore_a;
  logic [11:0] score_s, hiscore_s, score_w, hiscore_w;
  logic running_a, new_hi_a, milestone_a;
  logic running_s, new_hi_s, milestone_s;
  logic running_w, new_hi_w, milestone_w;
  int n_cmp = 0, n_bad = 0;
  int ms_a = 0, ms_s = 0, ms_w = 0;

  always #5 clk = ~clk;

  dino_score_bcd u_dut (
    .clk(clk), .rst(rst), .game_start(start_a), .game_over(over_a), .game_tick(tick_a),
    .score(score_a), .hiscore(hiscore_a), .running(running_a), .new_hi(new_hi_a),
    .milestone(milestone_a));

  dino_score_bcd #(.DIGITS(3), .TICKS_PER_POINT(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .game_start(start_s), .game_over(over_s), .game_tick(tick_s),
    .score(score_s), .hiscore(hiscore_s), .running(running_s), .new_hi(new_hi_s),
    .milestone(milestone_s));

  dino_score_bcd #(.DIGITS(3), .TICKS_PER_POINT(1), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .game_start(start_s), .game_over(over_s), .game_tick(tick_s),
    .score(score_w), .hiscore(hiscore_w), .running(running_w), .new_hi(new_hi_w),
    .milestone(milestone_w));

  // Each cycle with milestone high is counted once, at the following edge.
  always @(posedge clk) begin
    if (milestone_a === 1'b1) ms_a++;
    if (milestone_s === 1'b1) ms_s++;
    if (milestone_w === 1'b1) ms_w++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // m = {start, over, tick}; returns on the falling edge where the result is visible.
  task automatic pulse_a(input logic [2:0] m);
    @(negedge clk); {start_a, over_a, tick_a} = m;
    @(negedge clk); {start_a, over_a, tick_a} = 3'b000;
  endtask

  task automatic ticks_a(input int n);
    repeat (n) pulse_a(3'b001);
  endtask

  task automatic pulse_s(input logic [2:0] m);
    @(negedge clk); {start_s, over_s, tick_s} = m;
    @(negedge clk); {start_s, over_s, tick_s} = 3'b000;
  endtask

  initial begin
    // 1: reset, ticks in IDLE ignored
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ticks_a(10);
    chk("idle_score", score_a, 32'h0);
    chk("idle_hiscore", hiscore_a, 32'h0);
    chk("idle_running", running_a, 32'h0);
    chk("idle_ms", ms_a, 32'd0);

    // 2: counting with divide-by-6
    pulse_a(3'b100);
    chk("start_running", running_a, 32'h1);
    ticks_a(5);
    chk("div_5_ticks", score_a, 32'h0);
    ticks_a(1);
    chk("div_6_ticks", score_a, 32'h1);
    ticks_a(54);
    chk("score_10", score_a, 32'h10);
    ticks_a(6);
    chk("score_11", score_a, 32'h11);
    ticks_a(528);
    chk("score_99", score_a, 32'h99);
    chk("no_ms_below_100", ms_a, 32'd0);
    ticks_a(5);
    chk("score_99_hold", score_a, 32'h99);
    ticks_a(1);
    chk("score_100", score_a, 32'h100);
    chk("ms_100_high", milestone_a, 32'h1);
    @(negedge clk);
    chk("ms_100_low", milestone_a, 32'h0);
    chk("ms_100_count", ms_a, 32'd1);

    // 3: high score
    ticks_a(138);
    chk("score_123", score_a, 32'h123);
    pulse_a(3'b010);
    chk("over_running", running_a, 32'h0);
    chk("over_hiscore", hiscore_a, 32'h123);
    chk("over_new_hi", new_hi_a, 32'h1);
    ticks_a(3);
    chk("over_hold_score", score_a, 32'h123);
    pulse_a(3'b100);
    chk("restart_score", score_a, 32'h0);
    chk("restart_new_hi", new_hi_a, 32'h0);
    chk("restart_running", running_a, 32'h1);
    ticks_a(300);
    chk("score_50", score_a, 32'h50);
    pulse_a(3'b010);
    chk("low_hiscore", hiscore_a, 32'h123);
    chk("low_new_hi", new_hi_a, 32'h0);
    chk("low_running", running_a, 32'h0);

    // 5: simultaneous and held inputs
    pulse_a(3'b100);
    ticks_a(5);
    pulse_a(3'b011);
    chk("over_tick_running", running_a, 32'h0);
    chk("over_tick_score", score_a, 32'h0);
    pulse_a(3'b100);
    pulse_a(3'b110);
    chk("start_over_running", running_a, 32'h0);
    pulse_a(3'b100);
    ticks_a(5);
    @(negedge clk); tick_a = 1'b1;
    repeat (10) @(negedge clk);
    tick_a = 1'b0;
    @(negedge clk);
    chk("held_tick_score", score_a, 32'h1);
    ticks_a(6);
    chk("after_held_score", score_a, 32'h2);
    pulse_a(3'b100);
    chk("midgame_start_running", running_a, 32'h1);
    chk("midgame_start_score", score_a, 32'h2);
    ticks_a(240);
    chk("score_42", score_a, 32'h42);

    // 6: mid-game reset, start held across reset release
    @(negedge clk); rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    chk("rst_score", score_a, 32'h0);
    chk("rst_hiscore", hiscore_a, 32'h0);
    chk("rst_running", running_a, 32'h0);
    chk("rst_new_hi", new_hi_a, 32'h0);
    chk("rst_milestone", milestone_a, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_start_idle", running_a, 32'h0);
    start_a = 1'b0;
    pulse_a(3'b100);
    chk("post_rst_running", running_a, 32'h1);
    chk("post_rst_score", score_a, 32'h0);
    ticks_a(6);
    chk("post_rst_score_1", score_a, 32'h1);

    // 4: max value, 3 digits, one tick per point
    pulse_s(3'b100);
    chk("small_running", running_s, 32'h1);
    repeat (999) pulse_s(3'b001);
    chk("sat_999", score_s, 32'h999);
    chk("wrap_999", score_w, 32'h999);
    pulse_s(3'b001);
    chk("sat_hold", score_s, 32'h999);
    chk("sat_no_ms", milestone_s, 32'h0);
    chk("wrap_zero", score_w, 32'h0);
    chk("wrap_ms_high", milestone_w, 32'h1);
    @(negedge clk);
    chk("wrap_ms_low", milestone_w, 32'h0);
    chk("sat_ms_count", ms_s, 32'd9);
    chk("wrap_ms_count", ms_w, 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dino_score_bcd.md
Name: dino_score_bcd

Overview:
Parametrised successor to the dino game score counter. It counts points in packed BCD from the 60 Hz frame tick, using a programmable ticks-per-point divider. It also keeps a high-score register, flags a new high score at game over, and emits a pulse at every 100-point milestone. It sits between the game-control logic (start/over/tick pulses) and the 7-segment or pin-out display path.

Parameters:
DIGITS, 4, number of BCD digits in score/hiscore; legal range 3..8.
TICKS_PER_POINT, 6, game_tick events per point (6 gives 10 pts/s at 60 Hz); legal range 1..255.
SATURATE, 1, 1 = score holds at all-9s; 0 = score wraps to all-0s.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
game_start  input  1  start/restart request; level, rising-edge detected internally.
game_over  input  1  end-of-game request; level, rising-edge detected internally.
game_tick  input  1  end-of-frame strobe (60 Hz); level, rising-edge detected internally.
score  output  4*DIGITS  current score, packed BCD, digit 0 in [3:0].
hiscore  output  4*DIGITS  best completed-game score, packed BCD.
running  output  1  high while state = RUNNING.
new_hi  output  1  high after a game ends with score > previous hiscore; cleared on next start.
milestone  output  1  one-cycle pulse when the tens digit carries out.

Behaviour:
- Reset, synchronous and active-high, is the only reset. It forces: score = 0, hiscore = 0, running = 0, new_hi = 0, milestone = 0, divider = 0, state = IDLE.
- The edge-detect registers reset to 1, so an input held high through reset produces no event.
- Event definitions: each event = in & ~in_q, with in_q registered every cycle. A level held high produces exactly one event.
- Latency: an event seen at clock edge N updates state, score and flags at edge N, visible in the next cycle. milestone asserts in that same cycle.
- State machine, IDLE:
  - start event -> RUNNING; score <= 0; divider <= 0; new_hi <= 0.
  - over and tick events are ignored.
- State machine, RUNNING:
  - over event -> OVER (priority over start and tick in the same cycle).
  - On that transition: if score > hiscore (unsigned BCD compare), then hiscore <= score and new_hi <= 1. Otherwise hiscore and new_hi are unchanged.
  - A start event without over is ignored (no restart mid-game).
  - tick event (without over): if divider == TICKS_PER_POINT-1, then divider <= 0 and score increments by 1 in BCD; otherwise divider <= divider+1.
- State machine, OVER:
  - score and hiscore hold.
  - start event -> RUNNING; score <= 0; divider <= 0; new_hi <= 0.
  - over and tick events are ignored.
- BCD increment: a digit at 9 goes to 0 and carries into the next digit. No digit ever holds A..F.
- Max score, SATURATE=1: score stays at all-9s, the divider keeps cycling, and no milestone is generated.
- Max score, SATURATE=0: score goes to all-0s and milestone pulses (the tens carry occurs).
- milestone: pulses only on an actual increment whose carry propagates out of digit 1.
- Divider width: clog2(TICKS_PER_POINT), minimum 1 bit. TICKS_PER_POINT=1 means every tick event increments score.
- Reset mid-operation, in any state: full reset values as above, including hiscore.
- running is a registered decode of state, with no glitches.

Test Plan:
1. Reset: assert rst 2 cycles, then pulse game_tick 10x in IDLE -> score 0x0000, hiscore 0x0000, running 0, milestone never 1.
2. Counting (defaults): start, then 60 tick pulses -> score 0x0010. 6 more -> 0x0011. Continue to 0x0099, then 6 ticks -> 0x0100 with milestone high exactly 1 cycle. Ticks 1..5 of each group leave score unchanged.
3. High score: over at 0x0123 -> running 0, hiscore 0x0123, new_hi 1. Start -> score 0x0000, new_hi 0. Over at 0x0050 -> hiscore 0x0123, new_hi 0.
4. Max value (DIGITS=3, TICKS_PER_POINT=1):
   - SATURATE=1: 1000 ticks -> score 0x999 held, 1000th tick gives no milestone.
   - SATURATE=0: the 1000th tick -> score 0x000, milestone 1 cycle.
5. Simultaneous and held inputs:
   - over+tick with divider=5 -> score unchanged, state OVER.
   - start+over while RUNNING -> OVER.
   - game_tick held high 10 cycles -> counts as one tick.
   - start held high through reset release -> stays IDLE.
6. Mid-game reset: RUNNING at score 0x0042 with hiscore 0x0123, assert rst -> next cycle all outputs 0, IDLE. A following start begins from 0x0000.
